// File: rtl/host_port_bridge.sv
// Host-side initiator: serializes whole-word writes/reads into PORTW beats on the core register-file port.
// Latency: write rsp SERSZ+1 cycles after accept; read rsp after the final returned beat or timeout. Holds rsp until rsp_ready.
module host_port_bridge #(
   parameter int WORDSZ   = 384,
   parameter int PORTW    = 64,
   parameter int PORTAW   = 16,
   parameter int RFSZLOG2 = 11,
   parameter int SUBAW    = 5,
   parameter int TIMEOUT  = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                core_busy,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [RFSZLOG2-1:0] req_addr,
   input  logic [WORDSZ-1:0]   req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [WORDSZ-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                wen,
   output logic [PORTAW-1:0]   waddr,
   output logic [PORTW-1:0]    wdata,
   output logic                ren,
   output logic [PORTAW-1:0]   raddr,
   input  logic [PORTW-1:0]    rdata,
   input  logic                rdata_valid
);

   localparam int SERSZ = (WORDSZ + PORTW - 1) / PORTW;
   localparam int BW    = SERSZ * PORTW;
   localparam int CW    = $clog2(SERSZ + 1);
   localparam int TW    = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;

   generate
      if (SERSZ > (1 << SUBAW)) begin : g_chk_sersz
         $error("host_port_bridge: SERSZ beats do not fit in SUBAW sub-word address bits");
      end
      if (RFSZLOG2 + SUBAW > PORTAW) begin : g_chk_aw
         $error("host_port_bridge: RFSZLOG2+SUBAW exceeds PORTAW");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ISSUE,
      RD_WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic [RFSZLOG2-1:0] addr;
      logic [WORDSZ-1:0]   wdata;
   } req_t;

   state_t              state, state_nxt;
   req_t                req_q, req_nxt;
   logic [CW-1:0]       iss_cnt, iss_cnt_nxt;
   logic [CW-1:0]       rd_cnt, rd_cnt_nxt;
   logic [TW-1:0]       timer, timer_nxt;
   logic [WORDSZ-1:0]   rd_word, rd_word_nxt;

   logic                wen_nxt, ren_nxt;
   logic [PORTAW-1:0]   waddr_nxt, raddr_nxt;
   logic [PORTW-1:0]    wdata_nxt;
   logic                rsp_valid_nxt, rsp_err_nxt;
   logic [WORDSZ-1:0]   rsp_rdata_nxt;

   logic [PORTAW-1:0]   beat_addr;
   logic [PORTW-1:0]    beat_data;
   logic                reading;
   logic                rd_all;

   assign req_ready = (state == IDLE) && !core_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         req_q     <= '0;
         iss_cnt   <= '0;
         rd_cnt    <= '0;
         timer     <= '0;
         rd_word   <= '0;
         wen       <= 1'b0;
         waddr     <= '0;
         wdata     <= '0;
         ren       <= 1'b0;
         raddr     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         req_q     <= req_nxt;
         iss_cnt   <= iss_cnt_nxt;
         rd_cnt    <= rd_cnt_nxt;
         timer     <= timer_nxt;
         rd_word   <= rd_word_nxt;
         wen       <= wen_nxt;
         waddr     <= waddr_nxt;
         wdata     <= wdata_nxt;
         ren       <= ren_nxt;
         raddr     <= raddr_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         rsp_err   <= rsp_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      req_nxt       = req_q;
      iss_cnt_nxt   = iss_cnt;
      rd_cnt_nxt    = rd_cnt;
      timer_nxt     = timer;
      rd_word_nxt   = rd_word;
      wen_nxt       = 1'b0;
      waddr_nxt     = '0;
      wdata_nxt     = '0;
      ren_nxt       = 1'b0;
      raddr_nxt     = '0;
      rsp_valid_nxt = rsp_valid;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;

      beat_addr = (PORTAW'(req_q.addr) << SUBAW) + PORTAW'(iss_cnt);
      beat_data = PORTW'(BW'(req_q.wdata) >> (int'(iss_cnt) * PORTW));

      // Returned beats are captured in any read state, including overlap with issue.
      reading = (state == RD_ISSUE) || (state == RD_WAIT);
      if (reading && rdata_valid && (rd_cnt < CW'(SERSZ))) begin
         rd_word_nxt = rd_word | WORDSZ'(BW'(rdata) << (int'(rd_cnt) * PORTW));
         rd_cnt_nxt  = rd_cnt + CW'(1);
      end
      rd_all = (rd_cnt_nxt == CW'(SERSZ));

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               req_nxt.addr  = req_addr;
               req_nxt.wdata = req_wdata;
               iss_cnt_nxt   = CW'(1);
               rd_cnt_nxt    = '0;
               rd_word_nxt   = '0;
               timer_nxt     = '0;
               if (req_write) begin
                  state_nxt = WR;
                  wen_nxt   = 1'b1;
                  waddr_nxt = PORTAW'(req_addr) << SUBAW;
                  wdata_nxt = PORTW'(req_wdata);
               end else begin
                  state_nxt = RD_ISSUE;
                  ren_nxt   = 1'b1;
                  raddr_nxt = PORTAW'(req_addr) << SUBAW;
               end
            end
         end
         WR: begin
            if (iss_cnt < CW'(SERSZ)) begin
               wen_nxt     = 1'b1;
               waddr_nxt   = beat_addr;
               wdata_nxt   = beat_data;
               iss_cnt_nxt = iss_cnt + CW'(1);
            end else begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = '0;
               rsp_err_nxt   = 1'b0;
            end
         end
         RD_ISSUE: begin
            if (iss_cnt < CW'(SERSZ)) begin
               ren_nxt     = 1'b1;
               raddr_nxt   = beat_addr;
               iss_cnt_nxt = iss_cnt + CW'(1);
            end else if (rd_all) begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = rd_word_nxt;
               rsp_err_nxt   = 1'b0;
            end else begin
               state_nxt = RD_WAIT;
               timer_nxt = '0;
            end
         end
         RD_WAIT: begin
            timer_nxt = timer + TW'(1);
            if (rd_all) begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = rd_word_nxt;
               rsp_err_nxt   = 1'b0;
            end else if (timer_nxt == TW'(TIMEOUT)) begin
               // Missing beats stay zero in the assembled word.
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = rd_word_nxt;
               rsp_err_nxt   = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
               rsp_rdata_nxt = '0;
               rsp_err_nxt   = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
